// File: rtl/rob_queue.sv
// Re-order buffer: in-order allocate, out-of-order writeback, in-order commit.
// Optional feature macro ROB_EXCEPTION_EN adds per-entry exception flags and self-flush on commit.
module rob_queue #(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned IDX_W       = 5,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned AREG_W      = 5,
    parameter int unsigned PREG_W      = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [PC_W-1:0]   alloc_pc_i,
    input  logic              alloc_has_dst_i,
    input  logic [AREG_W-1:0] alloc_areg_i,
    input  logic [PREG_W-1:0] alloc_preg_i,
    input  logic [PREG_W-1:0] alloc_old_preg_i,
    output logic [IDX_W-1:0]  alloc_idx_o,

    input  logic              wb_valid_i,
    input  logic [IDX_W-1:0]  wb_idx_i,
`ifdef ROB_EXCEPTION_EN
    input  logic              wb_exc_i,
    output logic              commit_exc_o,
`endif

    output logic              commit_valid_o,
    input  logic              commit_ready_i,
    output logic [PC_W-1:0]   commit_pc_o,
    output logic              commit_has_dst_o,
    output logic [AREG_W-1:0] commit_areg_o,
    output logic [PREG_W-1:0] commit_preg_o,
    output logic [PREG_W-1:0] commit_old_preg_o,

    input  logic              flush_i,
    output logic              empty_o,
    output logic              full_o,
    output logic [IDX_W:0]    count_o
);

    localparam logic [IDX_W:0] PtrOne = {{IDX_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]           head_q;
    logic [IDX_W:0]           tail_q;
    logic [IDX_W-1:0]         head_idx;
    logic [IDX_W-1:0]         tail_idx;

    logic [NUM_ENTRIES-1:0]   valid_q;
    logic [NUM_ENTRIES-1:0]   done_q;

    logic [PC_W-1:0]          pc_q       [NUM_ENTRIES];
    logic                     has_dst_q  [NUM_ENTRIES];
    logic [AREG_W-1:0]        areg_q     [NUM_ENTRIES];
    logic [PREG_W-1:0]        preg_q     [NUM_ENTRIES];
    logic [PREG_W-1:0]        old_preg_q [NUM_ENTRIES];

    logic                     alloc_fire;
    logic                     commit_fire;
    logic                     wb_hit;
    logic                     flush_all;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign empty_o       = (head_q == tail_q);
    assign full_o        = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign count_o       = tail_q - head_q;
    assign alloc_ready_o = !full_o;
    assign alloc_idx_o   = tail_idx;

    assign commit_valid_o    = valid_q[head_idx] && done_q[head_idx];
    assign commit_pc_o       = pc_q[head_idx];
    assign commit_has_dst_o  = has_dst_q[head_idx];
    assign commit_areg_o     = areg_q[head_idx];
    assign commit_preg_o     = preg_q[head_idx];
    assign commit_old_preg_o = old_preg_q[head_idx];

    assign alloc_fire  = alloc_valid_i && !full_o;
    assign commit_fire = commit_valid_o && commit_ready_i;
    assign wb_hit      = wb_valid_i && valid_q[wb_idx_i];

`ifdef ROB_EXCEPTION_EN
    logic [NUM_ENTRIES-1:0] exc_q;

    assign commit_exc_o = exc_q[head_idx];
    // Retiring a faulting entry discards everything younger, including this cycle's alloc.
    assign flush_all    = flush_i || (commit_fire && exc_q[head_idx]);

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_all) begin
            exc_q <= '0;
        end else begin
            if (wb_hit) begin
                exc_q[wb_idx_i] <= wb_exc_i;
            end
            if (alloc_fire) begin
                exc_q[tail_idx] <= 1'b0;
            end
        end
    end
`else
    assign flush_all = flush_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_all) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
                head_q            <= head_q + PtrOne;
            end
            // A wb racing its own commit is harmless: the slot is invalid from next cycle.
            if (wb_hit) begin
                done_q[wb_idx_i] <= 1'b1;
            end
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire && !flush_all && !reset_i) begin
            pc_q[tail_idx]       <= alloc_pc_i;
            has_dst_q[tail_idx]  <= alloc_has_dst_i;
            areg_q[tail_idx]     <= alloc_areg_i;
            preg_q[tail_idx]     <= alloc_preg_i;
            old_preg_q[tail_idx] <= alloc_old_preg_i;
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Directed-vector bench for rob_queue: table-driven basics plus hand-written fill, wrap and
// exception sequences.
module tb_rob_queue;
    localparam int unsigned NUM_ENTRIES = 32;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned AREG_W      = 5;
    localparam int unsigned PREG_W      = 6;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              alloc_valid_i;
    logic              alloc_ready_o;
    logic [PC_W-1:0]   alloc_pc_i;
    logic              alloc_has_dst_i;
    logic [AREG_W-1:0] alloc_areg_i;
    logic [PREG_W-1:0] alloc_preg_i;
    logic [PREG_W-1:0] alloc_old_preg_i;
    logic [IDX_W-1:0]  alloc_idx_o;
    logic              wb_valid_i;
    logic [IDX_W-1:0]  wb_idx_i;
    logic              commit_valid_o;
    logic              commit_ready_i;
    logic [PC_W-1:0]   commit_pc_o;
    logic              commit_has_dst_o;
    logic [AREG_W-1:0] commit_areg_o;
    logic [PREG_W-1:0] commit_preg_o;
    logic [PREG_W-1:0] commit_old_preg_o;
    logic              flush_i;
    logic              empty_o;
    logic              full_o;
    logic [IDX_W:0]    count_o;
`ifdef ROB_EXCEPTION_EN
    logic              wb_exc_i;
    logic              commit_exc_o;
`endif

    always #5 clk_i = ~clk_i;

    rob_queue #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W),
        .PC_W        (PC_W),
        .AREG_W      (AREG_W),
        .PREG_W      (PREG_W)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .alloc_valid_i     (alloc_valid_i),
        .alloc_ready_o     (alloc_ready_o),
        .alloc_pc_i        (alloc_pc_i),
        .alloc_has_dst_i   (alloc_has_dst_i),
        .alloc_areg_i      (alloc_areg_i),
        .alloc_preg_i      (alloc_preg_i),
        .alloc_old_preg_i  (alloc_old_preg_i),
        .alloc_idx_o       (alloc_idx_o),
        .wb_valid_i        (wb_valid_i),
        .wb_idx_i          (wb_idx_i),
`ifdef ROB_EXCEPTION_EN
        .wb_exc_i          (wb_exc_i),
        .commit_exc_o      (commit_exc_o),
`endif
        .commit_valid_o    (commit_valid_o),
        .commit_ready_i    (commit_ready_i),
        .commit_pc_o       (commit_pc_o),
        .commit_has_dst_o  (commit_has_dst_o),
        .commit_areg_o     (commit_areg_o),
        .commit_preg_o     (commit_preg_o),
        .commit_old_preg_o (commit_old_preg_o),
        .flush_i           (flush_i),
        .empty_o           (empty_o),
        .full_o            (full_o),
        .count_o           (count_o)
    );

    typedef struct {
        logic        av;
        logic [31:0] pc;
        logic        wv;
        logic [4:0]  widx;
        logic        cr;
        logic        fl;
        int          cnt;
        logic        cv;
        logic [31:0] cpc;
        logic [4:0]  aidx;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [31:0] pc, input logic wv,
                                input logic [4:0] widx, input logic cr, input logic fl,
                                input int cnt, input logic cv, input logic [31:0] cpc,
                                input logic [4:0] aidx);
        vec_t v;
        v.av = av; v.pc = pc; v.wv = wv; v.widx = widx; v.cr = cr; v.fl = fl;
        v.cnt = cnt; v.cv = cv; v.cpc = cpc; v.aidx = aidx;
        return v;
    endfunction

    // Payload side fields are derived from the PC so commit fields can be predicted from it.
    task automatic set_payload(input logic [31:0] pc);
        alloc_pc_i       = pc;
        alloc_has_dst_i  = pc[2];
        alloc_areg_i     = pc[6:2];
        alloc_preg_i     = pc[7:2];
        alloc_old_preg_i = pc[8:3];
    endtask

    task automatic chk_commit(input string tag, input logic [31:0] pc);
        chk({tag, " commit_pc"}, commit_pc_o, pc);
        chk({tag, " commit_has_dst"}, commit_has_dst_o, pc[2]);
        chk({tag, " commit_areg"}, commit_areg_o, pc[6:2]);
        chk({tag, " commit_preg"}, commit_preg_o, pc[7:2]);
        chk({tag, " commit_old_preg"}, commit_old_preg_o, pc[8:3]);
    endtask

    task automatic idle();
        alloc_valid_i  = 1'b0;
        set_payload(32'h0);
        wb_valid_i     = 1'b0;
        wb_idx_i       = '0;
        commit_ready_i = 1'b0;
        flush_i        = 1'b0;
`ifdef ROB_EXCEPTION_EN
        wb_exc_i       = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int          exp_tail;
        int          last_idx;
        int          retired;

        reset_i = 1'b1;
        idle();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        // Reset state, 3-entry out-of-order writeback, then flush with pending alloc.
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0, 1, 0, 32'h0,   1));
        vecs.push_back(mk(1, 32'h108, 0, 0, 0, 0, 2, 0, 32'h0,   2));
        vecs.push_back(mk(0, 32'h0,   1, 2, 1, 0, 3, 0, 32'h0,   3));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 0, 3, 0, 32'h0,   3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 0, 3, 1, 32'h100, 3));
        vecs.push_back(mk(0, 32'h0,   1, 1, 1, 0, 2, 0, 32'h0,   3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 0, 2, 1, 32'h104, 3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 0, 1, 1, 32'h108, 3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   3));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0, i, 0, 32'h0, 5'(3 + i)));
        end
        vecs.push_back(mk(1, 32'h400, 1, 3, 1, 1, 5, 0, 32'h0, 8));
        vecs.push_back(mk(0, 32'h0,   1, 3, 1, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 0, 0, 0, 32'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            idle();
            alloc_valid_i  = vecs[i].av;
            set_payload(vecs[i].pc);
            wb_valid_i     = vecs[i].wv;
            wb_idx_i       = vecs[i].widx;
            commit_ready_i = vecs[i].cr;
            flush_i        = vecs[i].fl;
            #1;
            chk($sformatf("v%0d count", i), count_o, vecs[i].cnt);
            chk($sformatf("v%0d empty", i), empty_o, vecs[i].cnt == 0);
            chk($sformatf("v%0d full", i), full_o, 1'b0);
            chk($sformatf("v%0d alloc_ready", i), alloc_ready_o, 1'b1);
            chk($sformatf("v%0d commit_valid", i), commit_valid_o, vecs[i].cv);
            chk($sformatf("v%0d alloc_idx", i), alloc_idx_o, vecs[i].aidx);
            if (vecs[i].cv) chk_commit($sformatf("v%0d", i), vecs[i].cpc);
        end

        // Fill to capacity with retire stalled; the extra request must be dropped.
        do_reset();
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            @(negedge clk_i);
            idle();
            alloc_valid_i = 1'b1;
            set_payload(32'h2000 + 32'(i * 4));
            #1;
            chk("fill alloc_idx", alloc_idx_o, i);
            chk("fill count", count_o, i);
        end
        @(negedge clk_i);
        idle();
        alloc_valid_i = 1'b1;
        set_payload(32'hDEAD0000);
        #1;
        chk("full full_o", full_o, 1'b1);
        chk("full alloc_ready", alloc_ready_o, 1'b0);
        chk("full count", count_o, NUM_ENTRIES);
        @(negedge clk_i);
        idle();
        #1;
        chk("overflow count", count_o, NUM_ENTRIES);
        chk("overflow commit_valid", commit_valid_o, 1'b0);

        // Mark all done, then alloc+commit while full (alloc rejected), then at 31 (both take).
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            @(negedge clk_i);
            idle();
            wb_valid_i = 1'b1;
            wb_idx_i   = 5'(i);
        end
        @(negedge clk_i);
        idle();
        alloc_valid_i  = 1'b1;
        set_payload(32'hBAD0);
        commit_ready_i = 1'b1;
        #1;
        chk("fullac commit_valid", commit_valid_o, 1'b1);
        chk_commit("fullac", 32'h2000);
        @(negedge clk_i);
        idle();
        alloc_valid_i  = 1'b1;
        set_payload(32'h3000);
        commit_ready_i = 1'b1;
        #1;
        chk("ac31 count", count_o, NUM_ENTRIES - 1);
        chk("ac31 alloc_idx", alloc_idx_o, 0);
        chk("ac31 commit_valid", commit_valid_o, 1'b1);
        chk_commit("ac31", 32'h2004);
        @(negedge clk_i);
        idle();
        #1;
        chk("after ac31 count", count_o, NUM_ENTRIES - 1);
        chk("after ac31 commit_valid", commit_valid_o, 1'b1);
        chk_commit("after ac31", 32'h2008);

        // 70 streaming allocs force the pointers around the ring twice.
        do_reset();
        exp_tail = 0;
        last_idx = -1;
        retired  = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk_i);
            idle();
            alloc_valid_i  = 1'b1;
            set_payload(32'h4000 + 32'(k * 4));
            commit_ready_i = 1'b1;
            if (last_idx >= 0) begin
                wb_valid_i = 1'b1;
                wb_idx_i   = 5'(last_idx);
            end
            #1;
            chk("wrap alloc_idx", alloc_idx_o, exp_tail % NUM_ENTRIES);
            chk("wrap alloc_ready", alloc_ready_o, 1'b1);
            if (commit_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("wrap spurious commit", commit_valid_o, 1'b0);
                end else begin
                    chk_commit("wrap", exp_q.pop_front());
                    retired++;
                end
            end
            exp_q.push_back(32'h4000 + 32'(k * 4));
            last_idx = exp_tail % NUM_ENTRIES;
            exp_tail++;
        end
        for (int d = 0; d < 8; d++) begin
            @(negedge clk_i);
            idle();
            commit_ready_i = 1'b1;
            if (d == 0) begin
                wb_valid_i = 1'b1;
                wb_idx_i   = 5'(last_idx);
            end
            #1;
            if (commit_valid_o && exp_q.size() != 0) begin
                chk_commit("drain", exp_q.pop_front());
                retired++;
            end
        end
        chk("wrap retired", retired, 70);
        chk("wrap empty", empty_o, 1'b1);
        chk("wrap count", count_o, 0);

`ifdef ROB_EXCEPTION_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            idle();
            alloc_valid_i = 1'b1;
            set_payload(32'h5000 + 32'(i * 4));
        end
        @(negedge clk_i);
        idle();
        wb_valid_i = 1'b1;
        wb_idx_i   = 5'd1;
        wb_exc_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) continue;
            @(negedge clk_i);
            idle();
            wb_valid_i = 1'b1;
            wb_idx_i   = 5'(i);
        end
        @(negedge clk_i);
        idle();
        commit_ready_i = 1'b1;
        #1;
        chk("exc idx0 commit_valid", commit_valid_o, 1'b1);
        chk("exc idx0 commit_exc", commit_exc_o, 1'b0);
        chk_commit("exc idx0", 32'h5000);
        @(negedge clk_i);
        idle();
        commit_ready_i = 1'b1;
        alloc_valid_i  = 1'b1;
        set_payload(32'h6000);
        #1;
        chk("exc idx1 commit_valid", commit_valid_o, 1'b1);
        chk("exc idx1 commit_exc", commit_exc_o, 1'b1);
        chk_commit("exc idx1", 32'h5004);
        @(negedge clk_i);
        idle();
        #1;
        chk("exc flush count", count_o, 0);
        chk("exc flush empty", empty_o, 1'b1);
        chk("exc flush commit_valid", commit_valid_o, 1'b0);
        chk("exc flush alloc_idx", alloc_idx_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
